// File: rtl/test_pattern_generator.sv
// Streaming video test-pattern source: color bars, grey gradient, checkerboard or solid
// RGB565 frames pushed into a downstream FIFO, one pixel per accepted write.
module test_pattern_generator #(
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter int NUM_COLOR_BARS = 8,
  parameter int CHECKER_LOG2   = 3,
  parameter int GAP_CYCLES     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  input  logic        queue_full,
  output logic [16:0] queue_data,
  output logic        queue_wr_en,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FRAME_START = 2'd1,
    ACTIVE      = 2'd2,
    GAP         = 2'd3
  } state_t;

  localparam logic [10:0] COL_LAST     = 11'(FRAME_WIDTH - 1);
  localparam logic [10:0] ROW_LAST     = 11'(FRAME_HEIGHT - 1);
  localparam logic [3:0]  BAR_LAST     = 4'(NUM_COLOR_BARS - 1);
  localparam logic [10:0] BAR_POS_LAST = 11'((FRAME_WIDTH / NUM_COLOR_BARS) - 1);
  localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
  localparam logic [11:0] WIDTH_12     = 12'(FRAME_WIDTH);
  // 64 = G_STEP*FRAME_WIDTH + G_REM, so each column adds G_STEP (+1 on remainder carry)
  localparam logic [5:0]  G_STEP       = 6'(64 / FRAME_WIDTH);
  localparam logic [10:0] G_REM        = 11'(64 % FRAME_WIDTH);

  state_t      state_q, state_d;
  logic [10:0] col_q, col_d;
  logic [10:0] row_q, row_d;
  logic [3:0]  bar_q, bar_d;
  logic [10:0] bar_pos_q, bar_pos_d;
  logic [5:0]  grad_q, grad_d;
  logic [10:0] grad_acc_q, grad_acc_d;
  logic [15:0] gap_q, gap_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] solid_q, solid_d;
  logic [16:0] data_q, data_d;
  logic        done_q, done_d;
  logic [15:0] count_q, count_d;

  logic [10:0] nxt_col_s;
  logic [10:0] nxt_row_s;
  logic [3:0]  nxt_bar_s;
  logic [10:0] nxt_bar_pos_s;
  logic [5:0]  nxt_grad_s;
  logic [10:0] nxt_grad_acc_s;
  logic [11:0] grad_sum_s;
  logic        col_wrap_s;
  logic        last_pix_s;
  logic        wr_en_s;
  state_t      exit_state_s;

  function automatic logic [15:0] bar_color_f(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      3'd7:    c = 16'h0000;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  function automatic logic [15:0] pixel_f(
    input logic [1:0]  m,
    input logic [15:0] s,
    input logic [10:0] c,
    input logic [10:0] r,
    input logic [2:0]  b,
    input logic [5:0]  g
  );
    logic [10:0] cr;
    logic [15:0] p;
    cr = (c ^ r) >> CHECKER_LOG2;
    case (m)
      2'd0:    p = bar_color_f(b);
      2'd1:    p = {g[5:1], g, g[5:1]};
      2'd2:    p = cr[0] ? 16'h0000 : 16'hFFFF;
      2'd3:    p = s;
      default: p = 16'h0000;
    endcase
    return p;
  endfunction

  assign wr_en_s      = (state_q == ACTIVE) && !queue_full;
  assign col_wrap_s   = (col_q == COL_LAST);
  assign last_pix_s   = col_wrap_s && (row_q == ROW_LAST);
  assign grad_sum_s   = {1'b0, grad_acc_q} + {1'b0, G_REM};
  assign exit_state_s = enable ? FRAME_START : IDLE;

  // Coordinates and per-column pattern state for the pixel after the current one.
  always_comb begin
    nxt_col_s      = col_q;
    nxt_row_s      = row_q;
    nxt_bar_s      = bar_q;
    nxt_bar_pos_s  = bar_pos_q;
    nxt_grad_s     = grad_q;
    nxt_grad_acc_s = grad_acc_q;
    if (col_wrap_s) begin
      nxt_col_s      = 11'd0;
      nxt_row_s      = row_q + 11'd1;
      nxt_bar_s      = 4'd0;
      nxt_bar_pos_s  = 11'd0;
      nxt_grad_s     = 6'd0;
      nxt_grad_acc_s = 11'd0;
    end else begin
      nxt_col_s = col_q + 11'd1;
      // the last bar absorbs any leftover columns
      if (bar_q == BAR_LAST) begin
        nxt_bar_s     = bar_q;
        nxt_bar_pos_s = bar_pos_q;
      end else if (bar_pos_q == BAR_POS_LAST) begin
        nxt_bar_s     = bar_q + 4'd1;
        nxt_bar_pos_s = 11'd0;
      end else begin
        nxt_bar_s     = bar_q;
        nxt_bar_pos_s = bar_pos_q + 11'd1;
      end
      if (grad_sum_s >= WIDTH_12) begin
        nxt_grad_s     = grad_q + G_STEP + 6'd1;
        nxt_grad_acc_s = 11'(grad_sum_s - WIDTH_12);
      end else begin
        nxt_grad_s     = grad_q + G_STEP;
        nxt_grad_acc_s = grad_sum_s[10:0];
      end
    end
  end

  // Frame sequencing FSM and pixel register next-state.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    bar_d      = bar_q;
    bar_pos_d  = bar_pos_q;
    grad_d     = grad_q;
    grad_acc_d = grad_acc_q;
    gap_d      = gap_q;
    mode_d     = mode_q;
    solid_d    = solid_q;
    data_d     = data_q;
    done_d     = 1'b0;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = FRAME_START;
        end else begin
          state_d = IDLE;
        end
      end
      FRAME_START: begin
        mode_d     = mode;
        solid_d    = solid_color;
        col_d      = 11'd0;
        row_d      = 11'd0;
        bar_d      = 4'd0;
        bar_pos_d  = 11'd0;
        grad_d     = 6'd0;
        grad_acc_d = 11'd0;
        data_d     = {1'b1, pixel_f(mode, solid_color, 11'd0, 11'd0, 3'd0, 6'd0)};
        state_d    = ACTIVE;
      end
      ACTIVE: begin
        if (wr_en_s && last_pix_s) begin
          done_d     = 1'b1;
          count_d    = count_q + 16'd1;
          data_d     = 17'd0;
          col_d      = 11'd0;
          row_d      = 11'd0;
          bar_d      = 4'd0;
          bar_pos_d  = 11'd0;
          grad_d     = 6'd0;
          grad_acc_d = 11'd0;
          gap_d      = 16'd0;
          state_d    = (GAP_CYCLES == 0) ? exit_state_s : GAP;
        end else if (wr_en_s) begin
          col_d      = nxt_col_s;
          row_d      = nxt_row_s;
          bar_d      = nxt_bar_s;
          bar_pos_d  = nxt_bar_pos_s;
          grad_d     = nxt_grad_s;
          grad_acc_d = nxt_grad_acc_s;
          data_d     = {1'b0, pixel_f(mode_q, solid_q, nxt_col_s, nxt_row_s,
                                      nxt_bar_s[2:0], nxt_grad_s)};
          state_d    = ACTIVE;
        end else begin
          state_d = ACTIVE;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = 16'd0;
          state_d = exit_state_s;
        end else begin
          gap_d   = gap_q + 16'd1;
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      col_q      <= 11'd0;
      row_q      <= 11'd0;
      bar_q      <= 4'd0;
      bar_pos_q  <= 11'd0;
      grad_q     <= 6'd0;
      grad_acc_q <= 11'd0;
      gap_q      <= 16'd0;
      mode_q     <= 2'd0;
      solid_q    <= 16'd0;
      data_q     <= 17'd0;
      done_q     <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      bar_q      <= bar_d;
      bar_pos_q  <= bar_pos_d;
      grad_q     <= grad_d;
      grad_acc_q <= grad_acc_d;
      gap_q      <= gap_d;
      mode_q     <= mode_d;
      solid_q    <= solid_d;
      data_q     <= data_d;
      done_q     <= done_d;
      count_q    <= count_d;
    end
  end

  assign queue_wr_en = wr_en_s;
  assign queue_data  = data_q;
  assign frame_done  = done_q;
  assign frame_count = count_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_test_pattern_generator.sv
// Scoreboard bench for test_pattern_generator: expected frames are queued when the
// pattern is selected and popped on every FIFO write.
module tb_test_pattern_generator;

  localparam int W   = 640;
  localparam int H   = 20;
  localparam int N   = 10;
  localparam int L   = 3;
  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        queue_full = 1'b0;
  logic [16:0] queue_data;
  logic        queue_wr_en;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        busy;

  typedef struct {
    logic [16:0] data;
    int          col;
    int          row;
    int          md;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   writes_in_frame = 0;
  int   writes_total = 0;
  int   done_frames = 0;
  bit   stall_en = 1'b0;

  test_pattern_generator #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .NUM_COLOR_BARS(N),
    .CHECKER_LOG2(L), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
    .solid_color(solid_color), .queue_full(queue_full), .queue_data(queue_data),
    .queue_wr_en(queue_wr_en), .frame_done(frame_done), .frame_count(frame_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pix(input int md, input logic [15:0] s,
                                            input int c, input int r);
    int bar;
    logic [5:0] g;
    logic [15:0] p;
    case (md)
      0: begin
        bar = c / (W / N);
        if (bar > N - 1) bar = N - 1;
        case (bar % 8)
          0: p = 16'hFFFF;
          1: p = 16'hFFE0;
          2: p = 16'h07FF;
          3: p = 16'h07E0;
          4: p = 16'hF81F;
          5: p = 16'hF800;
          6: p = 16'h001F;
          default: p = 16'h0000;
        endcase
      end
      1: begin
        g = 6'((c * 64) / W);
        p = {g[5:1], g, g[5:1]};
      end
      2: p = ((((c >> L) ^ (r >> L)) & 1) == 0) ? 16'hFFFF : 16'h0000;
      default: p = s;
    endcase
    return p;
  endfunction

  task automatic push_frame(input int md, input logic [15:0] s);
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.data = {(c == 0 && r == 0) ? 1'b1 : 1'b0, model_pix(md, s, c, r)};
        e.col  = c;
        e.row  = r;
        e.md   = md;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_pix(input int f, input int p);
    bit ok = 1'b0;
    for (int i = 0; i < 40000 && !ok; i++) begin
      @(negedge clk);
      if (done_frames == f && writes_in_frame >= p) ok = 1'b1;
    end
    chk("wait_pixel_timeout", {31'd0, ok}, 32'd1);
  endtask

  // FIFO backpressure: random full cycles while stalling is enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      queue_full = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every write and checks frame boundaries.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        writes_in_frame = 0;
        done_frames = 0;
      end else begin
        if (frame_done) begin
          chk("frame_count", {16'd0, frame_count}, done_frames + 1);
          chk("frame_writes", writes_in_frame, W * H);
          done_frames++;
          writes_in_frame = 0;
        end
        if (queue_wr_en) begin
          chk("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pixel", {15'd0, queue_data}, {15'd0, e.data});
            if (e.col == 0 && e.row == 0) chk("flag_first", {31'd0, queue_data[16]}, 32'd1);
            else chk("flag_other", {31'd0, queue_data[16]}, 32'd0);
            if (e.md == 0 && e.row == 0 && (e.col == 0 || e.col == 63))
              chk("bar0", {16'd0, queue_data[15:0]}, 32'hFFFF);
            if (e.md == 0 && e.row == 0 && (e.col == 64 || e.col == 639))
              chk("bar1_or_clamp", {16'd0, queue_data[15:0]}, 32'hFFE0);
            if (e.md == 2 && ((e.col == 0 && e.row == 0) || (e.col == 8 && e.row == 8)))
              chk("checker_white", {16'd0, queue_data[15:0]}, 32'hFFFF);
            if (e.md == 2 && ((e.col == 8 && e.row == 0) || (e.col == 7 && e.row == 15)))
              chk("checker_black", {16'd0, queue_data[15:0]}, 32'h0000);
            if (e.md == 1 && e.row == 0 && e.col == 0)
              chk("grad_first", {16'd0, queue_data[15:0]}, 32'h0000);
            if (e.md == 1 && e.row == 0 && e.col == W - 1)
              chk("grad_last", {16'd0, queue_data[15:0]}, 32'hFFFF);
          end
          writes_in_frame++;
          writes_total++;
        end
      end
    end
  end

  initial begin
    int  n;
    int  saved;
    bit  ok;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", {31'd0, queue_wr_en}, 32'd0);
    chk("rst_data", {15'd0, queue_data}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_count", {16'd0, frame_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;

    // aborted frame: reset pulsed mid-frame
    push_frame(0, 16'h0000);
    enable = 1'b1;
    wait_pix(0, 5000);
    reset_n = 1'b0;
    #2;
    chk("midrst_wr_en", {31'd0, queue_wr_en}, 32'd0);
    chk("midrst_data", {15'd0, queue_data}, 32'd0);
    chk("midrst_count", {16'd0, frame_count}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    push_frame(0, 16'h0000);
    reset_n = 1'b1;

    // F1 color bars, F2 checker
    wait_pix(0, 100);
    chk("count_before_done", {16'd0, frame_count}, 32'd0);
    mode = 2'd2;
    push_frame(2, 16'h0000);
    // F3 gradient under backpressure
    wait_pix(1, 100);
    mode = 2'd1;
    push_frame(1, 16'h0000);
    wait_pix(2, 0);
    stall_en = 1'b1;
    // F4 solid 0x1234, changed to 0xABCD mid-frame for F5
    wait_pix(2, 100);
    mode = 2'd3;
    solid_color = 16'h1234;
    push_frame(3, 16'h1234);
    wait_pix(3, 0);
    stall_en = 1'b0;
    wait_pix(3, 100);
    solid_color = 16'hABCD;
    push_frame(3, 16'hABCD);
    // F5: enable dropped early, frame must still complete
    wait_pix(4, 100);
    enable = 1'b0;

    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (frame_done) ok = 1'b1;
    end
    chk("last_done_timeout", {31'd0, ok}, 32'd1);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (!busy) ok = 1'b1;
    end
    chk("gap_length", n, GAP);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    saved = writes_total;
    repeat (40) @(negedge clk);
    chk("no_writes_idle", writes_total, saved);
    chk("final_count", {16'd0, frame_count}, 32'd5);
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
